// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampled UART receiver, majority-vote bit recovery,
//            framing-error and sticky overrun reporting.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    input  logic                 ack_i,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] SAMP_LO  = CNT_W'(OVERSAMPLE/2 - 1);
    localparam logic [CNT_W-1:0] SAMP_MID = CNT_W'(OVERSAMPLE/2);
    localparam logic [CNT_W-1:0] SAMP_HI  = CNT_W'(OVERSAMPLE/2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_sync;
    logic [1:0]           sync_fill;
    logic                 armed, armed_nxt;
    logic [CNT_W-1:0]     s_cnt, s_cnt_nxt;
    logic [BIT_W-1:0]     b_cnt, b_cnt_nxt;
    logic                 samp_lo, samp_lo_nxt;
    logic                 samp_mid, samp_mid_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 unread;
    logic                 load, stop_bad;
    logic                 majority;

    assign majority = (samp_lo & samp_mid) | (samp_lo & rx_sync) | (samp_mid & rx_sync);
    assign busy_o   = (state != IDLE);

    always_comb begin
        state_nxt    = state;
        armed_nxt    = armed;
        s_cnt_nxt    = s_cnt;
        b_cnt_nxt    = b_cnt;
        samp_lo_nxt  = samp_lo;
        samp_mid_nxt = samp_mid;
        shreg_nxt    = shreg;
        load         = 1'b0;
        stop_bad     = 1'b0;

        if (state == IDLE) begin
            // The synchronizer's reset value of 1 must not arm the detector;
            // only a genuinely observed high line does.
            if (sync_fill[1] && rx_sync) begin
                armed_nxt = 1'b1;
            end
            if (armed && !rx_sync) begin
                state_nxt = START;
                s_cnt_nxt = '0;
                armed_nxt = 1'b0;
            end
        end else if (tick_i) begin
            s_cnt_nxt = (s_cnt == CNT_LAST) ? '0 : s_cnt + CNT_W'(1);
            if (s_cnt == SAMP_LO) begin
                samp_lo_nxt = rx_sync;
            end
            if (s_cnt == SAMP_MID) begin
                samp_mid_nxt = rx_sync;
            end

            case (state)
                START: begin
                    if (s_cnt == SAMP_HI && majority) begin
                        state_nxt = IDLE;
                    end else if (s_cnt == CNT_LAST) begin
                        state_nxt = DATA;
                        b_cnt_nxt = '0;
                    end
                end
                DATA: begin
                    if (s_cnt == SAMP_HI) begin
                        shreg_nxt = {majority, shreg[DATA_BITS-1:1]};
                    end
                    if (s_cnt == CNT_LAST) begin
                        if (b_cnt == BIT_LAST) begin
                            state_nxt = STOP;
                        end else begin
                            b_cnt_nxt = b_cnt + BIT_W'(1);
                        end
                    end
                end
                STOP: begin
                    // Leave at mid-stop so a following start edge is not missed.
                    if (s_cnt == SAMP_HI) begin
                        load      = 1'b1;
                        stop_bad  = !majority;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_sync     <= 1'b1;
            sync_fill   <= 2'b00;
            state       <= IDLE;
            armed       <= 1'b0;
            s_cnt       <= '0;
            b_cnt       <= '0;
            samp_lo     <= 1'b0;
            samp_mid    <= 1'b0;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            unread      <= 1'b0;
        end else begin
            rx_meta     <= rx_i;
            rx_sync     <= rx_meta;
            sync_fill   <= {sync_fill[0], 1'b1};
            state       <= state_nxt;
            armed       <= armed_nxt;
            s_cnt       <= s_cnt_nxt;
            b_cnt       <= b_cnt_nxt;
            samp_lo     <= samp_lo_nxt;
            samp_mid    <= samp_mid_nxt;
            shreg       <= shreg_nxt;
            valid_o     <= load;
            frame_err_o <= stop_bad;
            if (load) begin
                data_o    <= shreg;
                unread    <= 1'b1;
                overrun_o <= !ack_i && (overrun_o || unread);
            end else if (ack_i) begin
                unread    <= 1'b0;
                overrun_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (table plus corner cases).
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int DB       = 8;
    localparam int OS       = 16;
    localparam int TICK_DIV = 4;
    localparam int BIT_CLKS = OS * TICK_DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_i = 1'b0;
    logic          rx_i = 1'b1;
    logic          ack_i = 1'b0;
    logic [DB-1:0] data_o;
    logic          valid_o, frame_err_o, overrun_o, busy_o;

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_i      (tick_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .ack_i       (ack_i),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int fall_cyc = 0;

    initial forever begin
        @(posedge clk);
        #1;
        cyc    = cyc + 1;
        tick_i = (cyc % TICK_DIV == 0);
    end

    // Valid-pulse monitor: one count per high cycle, so a stretched pulse shows up.
    int            v_cnt = 0;
    logic [DB-1:0] v_data = '0;
    logic          v_ferr = 1'b0;
    int            v_cyc = 0;
    int            stray_ferr = 0;
    always @(negedge clk) begin
        if (valid_o) begin
            v_cnt  <= v_cnt + 1;
            v_data <= data_o;
            v_ferr <= frame_err_o;
            v_cyc  <= cyc;
        end else if (frame_err_o) begin
            stray_ferr <= stray_ferr + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic val, input logic noise);
        if (noise) begin
            // Inverted for exactly one tick period, landing on the middle sample.
            rx_i = val;
            wait_clk(34);
            rx_i = ~val;
            wait_clk(TICK_DIV);
            rx_i = val;
            wait_clk(BIT_CLKS - 34 - TICK_DIV);
        end else begin
            rx_i = val;
            wait_clk(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input logic noise);
        fall_cyc = cyc;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < DB; i++) begin
            drive_bit(b[i], noise);
        end
        drive_bit(stop, 1'b0);
    endtask

    task automatic pulse_ack();
        ack_i = 1'b1;
        wait_clk(1);
        ack_i = 1'b0;
        wait_clk(1);
    endtask

    typedef struct {
        logic [DB-1:0] data;
        logic          noise;
        logic [DB-1:0] exp_data;
        logic          exp_ferr;
    } vec_t;

    vec_t vecs[6];
    int   v0;
    int   lat;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, 8'h5A, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 1'b0, 8'h80, 1'b0};

        rst  = 1'b1;
        rx_i = 1'b1;
        wait_clk(4);
        check("reset_data",    int'(data_o),      0);
        check("reset_valid",   int'(valid_o),     0);
        check("reset_ferr",    int'(frame_err_o), 0);
        check("reset_overrun", int'(overrun_o),   0);
        check("reset_busy",    int'(busy_o),      0);
        rst = 1'b0;
        wait_clk(8);

        for (int i = 0; i < 6; i++) begin
            v0 = v_cnt;
            send_frame(vecs[i].data, 1'b1, vecs[i].noise);
            wait_clk(BIT_CLKS);
            check($sformatf("vec%0d_valid_count", i), v_cnt - v0, 1);
            check($sformatf("vec%0d_data", i), int'(v_data), int'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), int'(v_ferr), int'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_busy", i), int'(busy_o), 0);
            check($sformatf("vec%0d_overrun", i), int'(overrun_o), 0);
            if (i == 0) begin
                // 9 bits + mid-stop sample (154 ticks at 4 clk) plus sync delay.
                lat = v_cyc - fall_cyc;
                check("vec0_latency_window", int'(lat >= 600 && lat <= 640), 1);
            end
            pulse_ack();
        end

        // Short low glitch: start aborts at mid-bit decision.
        v0 = v_cnt;
        rx_i = 1'b0;
        wait_clk(3 * TICK_DIV);
        rx_i = 1'b1;
        check("glitch_busy_high", int'(busy_o), 1);
        wait_clk(BIT_CLKS);
        check("glitch_busy_low", int'(busy_o), 0);
        check("glitch_no_valid", v_cnt - v0, 0);

        // Framing error followed by a held-low line.
        v0 = v_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clk(3 * 10 * BIT_CLKS);
        check("break_valid_count", v_cnt - v0, 1);
        check("break_data", int'(v_data), 8'h3C);
        check("break_ferr", int'(v_ferr), 1);
        check("break_busy", int'(busy_o), 0);
        rx_i = 1'b1;
        wait_clk(BIT_CLKS);
        pulse_ack();
        send_frame(8'h81, 1'b1, 1'b0);
        wait_clk(BIT_CLKS);
        check("after_break_count", v_cnt - v0, 2);
        check("after_break_data", int'(v_data), 8'h81);
        check("after_break_ferr", int'(v_ferr), 0);
        pulse_ack();

        // Back-to-back frames without ack.
        v0 = v_cnt;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clk(BIT_CLKS);
        check("ovr_valid_count", v_cnt - v0, 2);
        check("ovr_data", int'(data_o), 8'h22);
        check("ovr_flag_set", int'(overrun_o), 1);
        pulse_ack();
        check("ovr_flag_cleared", int'(overrun_o), 0);
        send_frame(8'h66, 1'b1, 1'b0);
        wait_clk(BIT_CLKS);
        check("post_ack_data", int'(data_o), 8'h66);
        check("post_ack_no_overrun", int'(overrun_o), 0);
        pulse_ack();

        // Reset in the middle of data bit 4 of 0x0F, line low afterwards.
        v0 = v_cnt;
        rx_i = 1'b0;
        wait_clk(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx_i = 1'b1;
            wait_clk(BIT_CLKS);
        end
        rx_i = 1'b0;
        wait_clk(BIT_CLKS / 2);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        wait_clk(2);
        check("rst_busy_low", int'(busy_o), 0);
        wait_clk(BIT_CLKS / 2 + 3 * BIT_CLKS - 2);
        check("rst_low_line_no_start", int'(busy_o), 0);
        rx_i = 1'b1;
        wait_clk(2 * BIT_CLKS);
        check("rst_no_valid", v_cnt - v0, 0);
        check("rst_data_cleared", int'(data_o), 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clk(BIT_CLKS);
        check("rst_next_count", v_cnt - v0, 1);
        check("rst_next_data", int'(v_data), 8'hC3);
        check("rst_next_ferr", int'(v_ferr), 0);

        check("no_stray_frame_err", stray_ferr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
